// File: rtl/uvmt_axil_st_pkg.sv
// Shared definitions for the AXI-Lite self-test slave responder.
package uvmt_axil_st_pkg;

    localparam logic [1:0] UVMT_AXIL_ST_RESP_OKAY   = 2'b00;
    localparam logic [1:0] UVMT_AXIL_ST_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_ADDR,
        WR_HAVE_DATA,
        WR_RESP
    } uvmt_axil_st_slv_wr_st_enum;

endpackage

// File: rtl/uvmt_axil_st_slv_wr_fsm.sv
// AW/W capture, write FSM and B channel; emits a one-cycle commit strobe
// on the edge that enters RESP.
module uvmt_axil_st_slv_wr_fsm
    import uvmt_axil_st_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int OFFS  = $clog2(DATA_WIDTH / 8),
    localparam int IDXW  = $clog2(DEPTH),
    localparam int WAW   = ADDR_WIDTH - OFFS,
    localparam int STRBW = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [WAW-1:0]        awaddr_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [STRBW-1:0]      wstrb_i,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    output logic [1:0]            bresp_o,
    output logic                  we_o,
    output logic [IDXW-1:0]       we_idx_o,
    output logic [DATA_WIDTH-1:0] we_data_o,
    output logic [STRBW-1:0]      we_strb_o
);

    uvmt_axil_st_slv_wr_st_enum state_q, state_d;
    logic [WAW-1:0]        addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [STRBW-1:0]      strb_q, strb_d;
    logic [1:0]            bresp_q, bresp_d;

    logic                  aw_hs, w_hs, commit, in_range;
    logic [WAW-1:0]        sel_waddr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [STRBW-1:0]      sel_strb;

    assign awready_o = (state_q == WR_IDLE) || (state_q == WR_HAVE_DATA);
    assign wready_o  = (state_q == WR_IDLE) || (state_q == WR_HAVE_ADDR);
    assign bvalid_o  = (state_q == WR_RESP);
    assign bresp_o   = bresp_q;
    assign aw_hs     = awvalid_i && awready_o;
    assign w_hs      = wvalid_i && wready_o;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        commit    = 1'b0;
        sel_waddr = addr_q;
        sel_data  = data_q;
        sel_strb  = strb_q;
        case (state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    state_d   = WR_RESP;
                    commit    = 1'b1;
                    sel_waddr = awaddr_i;
                    sel_data  = wdata_i;
                    sel_strb  = wstrb_i;
                end else if (aw_hs) begin
                    state_d = WR_HAVE_ADDR;
                    addr_d  = awaddr_i;
                end else if (w_hs) begin
                    state_d = WR_HAVE_DATA;
                    data_d  = wdata_i;
                    strb_d  = wstrb_i;
                end
            end
            WR_HAVE_ADDR: begin
                if (w_hs) begin
                    state_d  = WR_RESP;
                    commit   = 1'b1;
                    sel_data = wdata_i;
                    sel_strb = wstrb_i;
                end
            end
            WR_HAVE_DATA: begin
                if (aw_hs) begin
                    state_d   = WR_RESP;
                    commit    = 1'b1;
                    sel_waddr = awaddr_i;
                end
            end
            WR_RESP: begin
                if (bready_i) state_d = WR_IDLE;
            end
            default: state_d = WR_IDLE;
        endcase
    end

    // Any address bit above the index field set means the word is past DEPTH.
    assign in_range  = (sel_waddr >> IDXW) == '0;
    assign bresp_d   = commit ? (in_range ? UVMT_AXIL_ST_RESP_OKAY : UVMT_AXIL_ST_RESP_SLVERR)
                              : bresp_q;
    assign we_o      = commit && in_range;
    assign we_idx_o  = sel_waddr[IDXW-1:0];
    assign we_data_o = sel_data;
    assign we_strb_o = sel_strb;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WR_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            bresp_q <= UVMT_AXIL_ST_RESP_OKAY;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            bresp_q <= bresp_d;
        end
    end

endmodule

// File: rtl/uvmt_axil_st_slv_mem.sv
// AXI-Lite slave responder backed by a word-addressed register memory.
// Read path and storage live here; the write handshake is in the FSM sub-module.
module uvmt_axil_st_slv_mem
    import uvmt_axil_st_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic [2:0]                awprot,
    input  logic                      wvalid,
    output logic                      wready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      bvalid,
    input  logic                      bready,
    output logic [1:0]                bresp,
    input  logic                      arvalid,
    output logic                      arready,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic [2:0]                arprot,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp
);

    localparam int OFFS  = $clog2(DATA_WIDTH / 8);
    localparam int IDXW  = $clog2(DEPTH);
    localparam int WAW   = ADDR_WIDTH - OFFS;
    localparam int STRBW = DATA_WIDTH / 8;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
    logic                  we;
    logic [IDXW-1:0]       we_idx;
    logic [DATA_WIDTH-1:0] we_data;
    logic [STRBW-1:0]      we_strb;

    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [WAW-1:0]        ar_waddr;
    logic                  ar_hs, ar_in_range;

    // Protection bits and byte-offset address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{awprot, arprot, awaddr[OFFS-1:0], araddr[OFFS-1:0]};

    uvmt_axil_st_slv_wr_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_wr_fsm (
        .clk       (clk),
        .reset     (reset),
        .awvalid_i (awvalid),
        .awready_o (awready),
        .awaddr_i  (awaddr[ADDR_WIDTH-1:OFFS]),
        .wvalid_i  (wvalid),
        .wready_o  (wready),
        .wdata_i   (wdata),
        .wstrb_i   (wstrb),
        .bvalid_o  (bvalid),
        .bready_i  (bready),
        .bresp_o   (bresp),
        .we_o      (we),
        .we_idx_o  (we_idx),
        .we_data_o (we_data),
        .we_strb_o (we_strb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '0;
        end else if (we) begin
            for (int b = 0; b < STRBW; b++) begin
                if (we_strb[b]) mem_q[we_idx][8*b +: 8] <= we_data[8*b +: 8];
            end
        end
    end

    assign ar_waddr    = araddr[ADDR_WIDTH-1:OFFS];
    assign ar_in_range = (ar_waddr >> IDXW) == '0;
    assign arready     = !rvalid_q;
    assign ar_hs       = arvalid && arready;

    // mem_q is sampled before a same-edge commit lands, so colliding reads see old data.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = ar_in_range ? mem_q[ar_waddr[IDXW-1:0]] : '0;
            rresp_d  = ar_in_range ? UVMT_AXIL_ST_RESP_OKAY : UVMT_AXIL_ST_RESP_SLVERR;
        end else if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= UVMT_AXIL_ST_RESP_OKAY;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;

endmodule

// File: tb/tb_uvmt_axil_st_slv_mem.sv
// Directed plus randomized bench for the AXI-Lite slave memory, checked
// against a word-array reference model.
module tb_uvmt_axil_st_slv_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  wstrb;
    logic [2:0]  awprot, arprot;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl [16];

    uvmt_axil_st_slv_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16)) dut (
        .clk(clk), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic in_rng(input logic [31:0] a);
        return (a / 4) < 16;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return in_rng(a) ? 2'b00 : 2'b10;
    endfunction

    task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (in_rng(a))
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[a / 4][8*b +: 8] = d[8*b +: 8];
    endtask

    function automatic logic [31:0] mdl_read(input logic [31:0] a);
        return in_rng(a) ? mdl[a / 4] : 32'h0;
    endfunction

    // Full write with AW and W together; response expected the cycle after.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        while (!bvalid && n < 20) begin step(); n++; end
        chk("wr_bvalid", 32'(bvalid), 32'd1);
        chk("wr_latency", 32'(n), 32'd0);
        chk("wr_bresp", 32'(bresp), 32'(exp_resp(a)));
        mdl_write(a, d, s);
        step();
        chk("wr_bdone", 32'(bvalid), 32'd0);
    endtask

    task automatic rd(input logic [31:0] a);
        int n = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        step();
        arvalid = 1'b0;
        while (!rvalid && n < 20) begin step(); n++; end
        chk("rd_rvalid", 32'(rvalid), 32'd1);
        chk("rd_latency", 32'(n), 32'd0);
        chk("rd_rdata", rdata, mdl_read(a));
        chk("rd_rresp", 32'(rresp), 32'(exp_resp(a)));
        step();
        chk("rd_rdone", 32'(rvalid), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; awprot = 3'h5; arprot = 3'h2;
        for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
        step(); step();
        chk("rst_awready", 32'(awready), 32'd1);
        chk("rst_wready", 32'(wready), 32'd1);
        chk("rst_arready", 32'(arready), 32'd1);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_bresp", 32'(bresp), 32'd0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        reset = 1'b0;

        // Write then read back.
        wr(32'h8, 32'hDEADBEEF, 4'hF);
        rd(32'h8);
        chk("wr_rd_value", mdl[2], 32'hDEADBEEF);

        // Partial strobe merges into existing word.
        wr(32'h4, 32'h11223344, 4'hF);
        wr(32'h4, 32'hAABBCCDD, 4'h5);
        rd(32'h4);
        chk("partial_model", mdl[1], 32'h11BB33DD);

        // Split channels: W first, AW three cycles later, B stalled.
        wdata = 32'h12345678; wstrb = 4'hF; awaddr = 32'hC; wvalid = 1'b1; bready = 1'b0;
        step();
        wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("split_wready_lo", 32'(wready), 32'd0);
            chk("split_awready_hi", 32'(awready), 32'd1);
            chk("split_no_b", 32'(bvalid), 32'd0);
            step();
        end
        awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("split_bvalid_hold", 32'(bvalid), 32'd1);
            chk("split_bresp", 32'(bresp), 32'd0);
            chk("split_awready_lo", 32'(awready), 32'd0);
            chk("split_wready_lo2", 32'(wready), 32'd0);
            step();
        end
        bready = 1'b1;
        step();
        chk("split_bdone", 32'(bvalid), 32'd0);
        chk("split_ready_back", 32'({awready, wready}), 32'd3);
        mdl_write(32'hC, 32'h12345678, 4'hF);
        rd(32'hC);

        // Out of range write leaves memory untouched.
        wr(32'h40, 32'h5, 4'hF);
        for (int i = 0; i < 16; i++) rd(32'(i * 4));
        rd(32'h40);

        // Read backpressure.
        araddr = 32'h8; arvalid = 1'b1; rready = 1'b0;
        step();
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rvalid", 32'(rvalid), 32'd1);
            chk("bp_rdata", rdata, mdl[2]);
            chk("bp_arready", 32'(arready), 32'd0);
            step();
        end
        rready = 1'b1;
        step();
        chk("bp_rdone", 32'(rvalid), 32'd0);
        chk("bp_arready_back", 32'(arready), 32'd1);

        // Read/write collision on word 0 returns pre-write data.
        awaddr = 32'h0; wdata = 32'h7; wstrb = 4'hF; araddr = 32'h0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("col_bvalid", 32'(bvalid), 32'd1);
        chk("col_rvalid", 32'(rvalid), 32'd1);
        chk("col_old_data", rdata, mdl[0]);
        step();
        mdl_write(32'h0, 32'h7, 4'hF);
        rd(32'h0);
        chk("col_new_model", mdl[0], 32'h7);

        // Randomized traffic, including out-of-range and unaligned addresses.
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = 32'(($urandom_range(0, 19) << 2) | $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) wr(a, $urandom, 4'($urandom_range(0, 15)));
            else rd(a);
        end

        // Reset mid-operation: AW held and R pending.
        awaddr = 32'h8; awvalid = 1'b1; araddr = 32'h8; arvalid = 1'b1; rready = 1'b0; bready = 1'b1;
        step();
        awvalid = 1'b0; arvalid = 1'b0;
        chk("mid_rvalid", 32'(rvalid), 32'd1);
        chk("mid_wready", 32'(wready), 32'd1);
        chk("mid_awready", 32'(awready), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
        chk("mr_awready", 32'(awready), 32'd1);
        chk("mr_wready", 32'(wready), 32'd1);
        chk("mr_arready", 32'(arready), 32'd1);
        chk("mr_bvalid", 32'(bvalid), 32'd0);
        chk("mr_rvalid", 32'(rvalid), 32'd0);
        chk("mr_rdata", rdata, 32'd0);
        rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mr_no_b", 32'(bvalid), 32'd0);
            chk("mr_no_r", 32'(rvalid), 32'd0);
        end
        rd(32'h8);
        rd(32'h4);
        rd(32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
